// File: rtl/acq_peak_detector_pkg.sv
// Shared types, sizes and helpers for the acquisition peak detector.
package acq_peak_detector_pkg;

    localparam int CODE_LEN = 2046;   // code phases per Doppler bin
    localparam int PHASE_W  = 12;
    localparam int BIN_W    = 8;
    localparam int PWR_W    = 32;
    localparam int EXCL     = 1;      // +-phases around the peak barred from the second peak
    localparam int THR_W    = 8;      // Q4.4 ratio threshold
    localparam int PROD_W   = PWR_W + THR_W;

    typedef logic [PHASE_W-1:0] phase_t;
    typedef logic [BIN_W-1:0]   bin_t;
    typedef logic [PWR_W-1:0]   pwr_t;
    typedef logic [PROD_W-1:0]  prod_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_EVAL1,
        ST_EVAL2,
        ST_REPORT
    } state_t;

    // A correlation candidate: power and the code phase it was seen at.
    typedef struct packed {
        pwr_t   pwr;
        phase_t phase;
    } cand_t;

    // Best-bin summary carried to the result outputs.
    typedef struct packed {
        logic   found;
        phase_t phase;
        bin_t   bin;
        pwr_t   peak;
        pwr_t   second;
    } result_t;

    // Distance between two code phases on the circular code.
    function automatic phase_t circdist(input phase_t a, input phase_t b);
        phase_t d;
        phase_t wrap;
        d    = (a >= b) ? (a - b) : (b - a);
        wrap = phase_t'(CODE_LEN) - d;
        return (d > wrap) ? wrap : d;
    endfunction

endpackage

// File: rtl/acq_peak_detector_if.sv
// Sample stream in and acquisition result out, bundled as one port.
interface acq_peak_detector_if;
    import acq_peak_detector_pkg::*;

    // Correlation power stream
    logic   s_valid;
    logic   s_ready;
    pwr_t   s_power;
    phase_t s_phase;
    bin_t   s_bin;
    logic   s_last;

    // Acquisition result
    logic   acq_valid;
    logic   acq_ready;
    logic   acq_found;
    phase_t acq_phase;
    bin_t   acq_bin;
    pwr_t   acq_peak;
    pwr_t   acq_second;
    logic   acq_error;

    // Producer of samples and consumer of results.
    modport master (
        output s_valid, s_power, s_phase, s_bin, s_last, acq_ready,
        input  s_ready, acq_valid, acq_found, acq_phase, acq_bin,
               acq_peak, acq_second, acq_error
    );

    // The peak detector itself.
    modport slave (
        input  s_valid, s_power, s_phase, s_bin, s_last, acq_ready,
        output s_ready, acq_valid, acq_found, acq_phase, acq_bin,
               acq_peak, acq_second, acq_error
    );

endinterface

// File: rtl/acq_peak_detector_peak_tracker.sv
// Per-bin peak / exclusion-windowed second-peak tracker with beat-count check.
module acq_peak_detector_peak_tracker
    import acq_peak_detector_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clear_i,      // start of a new bin
    input  logic   beat_i,       // accepted sample this cycle
    input  pwr_t   power_i,
    input  phase_t phase_i,
    input  logic   last_i,
    output cand_t  peak_o,
    output pwr_t   second_pwr_o,
    output logic   first_o,      // next beat is the first of the bin
    output logic   close_o,      // this beat ends the bin
    output logic   err_o         // this beat reveals a count mismatch
);

    cand_t  peak_q, peak_d;
    cand_t  second_q, second_d;
    phase_t count_q, count_d;
    logic   final_beat;
    logic   outside_excl;

    assign final_beat   = (count_q == phase_t'(CODE_LEN - 1));
    assign outside_excl = (circdist(phase_i, peak_q.phase) > phase_t'(EXCL));

    // Next peak/second/count: strict compares keep the earliest of equal powers.
    always_comb begin
        // NOTE: every target gets its hold value first so no path leaves it unassigned (no latch).
        peak_d   = peak_q;
        second_d = second_q;
        count_d  = count_q;
        if (clear_i) begin
            peak_d   = '0;
            second_d = '0;
            count_d  = '0;
        end else if (beat_i) begin
            count_d = count_q + 1'b1;
            if (power_i > peak_q.pwr) begin
                // The displaced peak only becomes the second if it lies outside the new window.
                if (outside_excl) begin
                    second_d = peak_q;
                end
                peak_d = '{pwr: power_i, phase: phase_i};
            end else if ((power_i > second_q.pwr) && outside_excl) begin
                second_d = '{pwr: power_i, phase: phase_i};
            end
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q   <= '0;
            second_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            peak_q   <= peak_d;
            second_q <= second_d;
            count_q  <= count_d;
        end
    end

    assign peak_o       = peak_q;
    assign second_pwr_o = second_q.pwr;
    assign first_o      = (count_q == '0);
    assign close_o      = beat_i & (last_i | final_beat);
    assign err_o        = beat_i & (last_i ^ final_beat);

endmodule

// File: rtl/acq_peak_detector.sv
// Doppler-sweep peak detector: per-bin ratio test, best-bin selection, result handshake.
module acq_peak_detector
    import acq_peak_detector_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  bin_t               num_bins,
    input  logic [THR_W-1:0]   ratio_thresh,
    output logic               busy,
    acq_peak_detector_if.slave bus
);

    state_t           state_q, state_d;
    bin_t             num_bins_q;
    bin_t             bins_done_q;
    bin_t             cur_bin_q;
    logic [THR_W-1:0] thresh_q;
    prod_t            lhs_q, rhs_q;
    result_t          best_q, best_d;
    logic             err_q;
    logic             acq_valid_q;

    logic             beat;
    logic             sweep_start;
    logic             clear_bin;
    logic             last_bin;
    logic [BIN_W:0]   done_inc;
    cand_t            peak;
    pwr_t             second_pwr;
    logic             first_beat;
    logic             bin_close;
    logic             count_err;

    assign bus.s_ready = (state_q == ST_COLLECT);
    assign beat        = bus.s_valid & bus.s_ready;
    assign busy        = (state_q != ST_IDLE);
    assign sweep_start = (state_q == ST_IDLE) & start;
    assign done_inc    = {1'b0, bins_done_q} + 1'b1;
    assign last_bin    = (done_inc >= {1'b0, num_bins_q});
    assign clear_bin   = (state_d == ST_COLLECT) && (state_q != ST_COLLECT);

    acq_peak_detector_peak_tracker u_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear_bin),
        .beat_i       (beat),
        .power_i      (bus.s_power),
        .phase_i      (bus.s_phase),
        .last_i       (bus.s_last),
        .peak_o       (peak),
        .second_pwr_o (second_pwr),
        .first_o      (first_beat),
        .close_o      (bin_close),
        .err_o        (count_err)
    );

    // Sweep sequencing: collect a bin, two evaluation cycles, repeat or report.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start)         state_d = ST_COLLECT;
            ST_COLLECT: if (bin_close)     state_d = ST_EVAL1;
            ST_EVAL1:                      state_d = ST_EVAL2;
            ST_EVAL2:   state_d = last_bin ? ST_REPORT : ST_COLLECT;
            ST_REPORT:  if (bus.acq_ready) state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sweep configuration, latched once per start; a bin count of 0 means one bin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_bins_q <= '0;
            thresh_q   <= '0;
        end else if (sweep_start) begin
            num_bins_q <= (num_bins == '0) ? bin_t'(1) : num_bins;
            thresh_q   <= ratio_thresh;
        end
    end

    // Ratio test operands at full width: peak*16 against second*threshold (Q4.4).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lhs_q <= '0;
            rhs_q <= '0;
        end else if (state_q == ST_EVAL1) begin
            lhs_q <= {{(THR_W - 4){1'b0}}, peak.pwr, 4'b0000};
            rhs_q <= prod_t'(second_pwr) * prod_t'(thresh_q);
        end
    end

    // Best-bin candidate: the first bin always seeds it, later bins must beat it strictly.
    always_comb begin
        best_d = best_q;
        if (sweep_start) begin
            best_d = '0;
        end else if ((state_q == ST_EVAL2) &&
                     ((bins_done_q == '0) || (peak.pwr > best_q.peak))) begin
            best_d.found  = (lhs_q > rhs_q);
            best_d.phase  = peak.phase;
            best_d.bin    = cur_bin_q;
            best_d.peak   = peak.pwr;
            best_d.second = second_pwr;
        end
    end

    // Best-bin register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q <= '0;
        end else begin
            best_q <= best_d;
        end
    end

    // Per-sweep bookkeeping: bin id, bins evaluated, sticky count error, result valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_bin_q   <= '0;
            bins_done_q <= '0;
            err_q       <= 1'b0;
            acq_valid_q <= 1'b0;
        end else begin
            if (beat && first_beat) begin
                cur_bin_q <= bus.s_bin;
            end
            if (sweep_start) begin
                bins_done_q <= '0;
                err_q       <= 1'b0;
            end else begin
                if (state_q == ST_EVAL2) begin
                    bins_done_q <= done_inc[BIN_W-1:0];
                end
                if (count_err) begin
                    err_q <= 1'b1;
                end
            end
            if ((state_q == ST_EVAL2) && last_bin) begin
                acq_valid_q <= 1'b1;
            end else if ((state_q == ST_REPORT) && bus.acq_ready) begin
                acq_valid_q <= 1'b0;
            end
        end
    end

    assign bus.acq_valid  = acq_valid_q;
    assign bus.acq_found  = best_q.found;
    assign bus.acq_phase  = best_q.phase;
    assign bus.acq_bin    = best_q.bin;
    assign bus.acq_peak   = best_q.peak;
    assign bus.acq_second = best_q.second;
    assign bus.acq_error  = err_q;

endmodule

// File: tb/tb_acq_peak_detector.sv
// Directed and randomized sweeps against a behavioural model of the peak detector.
module tb_acq_peak_detector;
    import acq_peak_detector_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    bin_t             num_bins = '0;
    logic [THR_W-1:0] ratio_thresh = '0;
    logic             busy;

    acq_peak_detector_if bus ();

    acq_peak_detector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_bins     (num_bins),
        .ratio_thresh (ratio_thresh),
        .busy         (busy),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int unsigned pw [CODE_LEN];

    // Sweep-level model state
    bit     m_first;
    int     m_thr;
    bit     m_found;
    int     m_phase;
    int     m_bin;
    longint m_peak;
    longint m_second;
    bit     m_err;

    // Expected result used by check_result
    bit     e_found;
    int     e_phase;
    int     e_bin;
    longint e_peak;
    longint e_second;
    bit     e_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cdist(input int a, input int b);
        int d;
        d = (a > b) ? a - b : b - a;
        return (d < CODE_LEN - d) ? d : CODE_LEN - d;
    endfunction

    function automatic void fill(input int unsigned v);
        for (int i = 0; i < CODE_LEN; i++) pw[i] = v;
    endfunction

    // Apply the peak/second rules to the first n powers, then fold into the sweep result.
    function automatic void model_bin(input int n, input int bin_id, input bit count_bad);
        longint pv = 0;
        longint sv = 0;
        int     pi = 0;
        bit     pass;
        for (int i = 0; i < n; i++) begin
            longint v = longint'(pw[i]);
            if (v > pv) begin
                if (cdist(i, pi) > EXCL) sv = pv;
                pv = v;
                pi = i;
            end else if (v > sv && cdist(i, pi) > EXCL) begin
                sv = v;
            end
        end
        pass = (pv * 16) > (sv * m_thr);
        if (m_first || pv > m_peak) begin
            m_found  = pass;
            m_phase  = pi;
            m_bin    = bin_id;
            m_peak   = pv;
            m_second = sv;
        end
        m_first = 1'b0;
        if (count_bad) m_err = 1'b1;
    endfunction

    function automatic void set_exp(input bit f, input int ph, input int bn,
                                    input longint pk, input longint sc, input bit er);
        e_found  = f;
        e_phase  = ph;
        e_bin    = bn;
        e_peak   = pk;
        e_second = sc;
        e_err    = er;
    endfunction

    function automatic void exp_from_model();
        set_exp(m_found, m_phase, m_bin, m_peak, m_second, m_err);
    endfunction

    task automatic check_result(input string tag);
        check({tag, ".valid"},  bus.acq_valid,  1);
        check({tag, ".found"},  bus.acq_found,  e_found);
        check({tag, ".phase"},  bus.acq_phase,  e_phase);
        check({tag, ".bin"},    bus.acq_bin,    e_bin);
        check({tag, ".peak"},   bus.acq_peak,   e_peak);
        check({tag, ".second"}, bus.acq_second, e_second);
        check({tag, ".error"},  bus.acq_error,  e_err);
    endtask

    task automatic begin_sweep(input int nb, input int thr);
        @(negedge clk);
        bus.s_valid  = 1'b0;
        num_bins     = bin_t'(nb);
        ratio_thresh = thr[THR_W-1:0];
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        m_first      = 1'b1;
        m_thr        = thr;
        m_err        = 1'b0;
    endtask

    task automatic send_beat(input int unsigned pwr, input int ph, input int bn, input bit last);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_power = pwr;
        bus.s_phase = phase_t'(ph);
        bus.s_bin   = bin_t'(bn);
        bus.s_last  = last;
        while (!bus.s_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check("s_ready_timeout", bus.s_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_bin(input int bin_id, input int n, input int last_at);
        for (int k = 0; k < n; k++) send_beat(pw[k], k, bin_id, k == last_at);
        model_bin(n, bin_id, !(n == CODE_LEN && last_at == CODE_LEN - 1));
    endtask

    // Called right after the final beat's accepting edge; that edge counts as cycle 1.
    task automatic finish_sweep(input string tag);
        int cyc;
        cyc = 1;
        while (!bus.acq_valid && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.s_valid = 1'b0;
        check({tag, ".latency"}, cyc, 3);
    endtask

    task automatic handshake(input string tag, input int hold);
        bus.acq_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_result({tag, ".hold"});
        end
        @(negedge clk);
        check_result(tag);
        bus.acq_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.acq_ready = 1'b0;
        check({tag, ".valid_drop"}, bus.acq_valid, 0);
        check({tag, ".busy_drop"},  busy,          0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},    busy,           0);
        check({tag, ".s_ready"}, bus.s_ready,    0);
        check({tag, ".valid"},   bus.acq_valid,  0);
        check({tag, ".found"},   bus.acq_found,  0);
        check({tag, ".phase"},   bus.acq_phase,  0);
        check({tag, ".bin"},     bus.acq_bin,    0);
        check({tag, ".peak"},    bus.acq_peak,   0);
        check({tag, ".second"},  bus.acq_second, 0);
        check({tag, ".error"},   bus.acq_error,  0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid   = 1'b0;
        bus.s_power   = '0;
        bus.s_phase   = '0;
        bus.s_bin     = '0;
        bus.s_last    = 1'b0;
        bus.acq_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");

        // Single bin: peak 1000@500, second 100@1500 against flat 10s
        begin_sweep(1, 8'h20);
        check("busy_after_start", busy, 1);
        fill(10);
        pw[500]  = 1000;
        pw[1500] = 100;
        send_bin(5, CODE_LEN, CODE_LEN - 1);
        finish_sweep("basic");
        set_exp(1, 500, 5, 1000, 100, 0);
        handshake("basic", 0);

        // Neighbour 900@501 is excluded; threshold edge 0x4F passes, 0x50 fails (16000 > 16000 is false)
        fill(0);
        pw[500] = 1000;
        pw[501] = 900;
        pw[0]   = 200;
        begin_sweep(1, 8'h4F);
        send_bin(1, CODE_LEN, CODE_LEN - 1);
        finish_sweep("thr4f");
        set_exp(1, 500, 1, 1000, 200, 0);
        handshake("thr4f", 0);
        begin_sweep(1, 8'h50);
        send_bin(1, CODE_LEN, CODE_LEN - 1);
        finish_sweep("thr50");
        set_exp(0, 500, 1, 1000, 200, 0);
        handshake("thr50", 0);

        // Circular exclusion across the 2045/0 wrap, in both directions
        fill(0);
        pw[0]    = 1000;
        pw[2045] = 950;
        pw[1000] = 300;
        begin_sweep(1, 8'h20);
        send_bin(2, CODE_LEN, CODE_LEN - 1);
        finish_sweep("wrap0");
        set_exp(1, 0, 2, 1000, 300, 0);
        handshake("wrap0", 0);
        fill(0);
        pw[2045] = 1000;
        pw[0]    = 950;
        pw[1000] = 300;
        begin_sweep(1, 8'h20);
        send_bin(2, CODE_LEN, CODE_LEN - 1);
        finish_sweep("wrap2045");
        set_exp(1, 2045, 2, 1000, 300, 0);
        handshake("wrap2045", 0);

        // Three bins, tied peaks keep the earlier bin; a mid-sweep start is ignored
        begin_sweep(3, 8'h20);
        fill(0);
        pw[100] = 500;
        send_bin(7, CODE_LEN, CODE_LEN - 1);
        @(negedge clk);
        num_bins = 8'd1;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        fill(0);
        pw[200] = 800;
        send_bin(8, CODE_LEN, CODE_LEN - 1);
        fill(0);
        pw[300] = 800;
        send_bin(9, CODE_LEN, CODE_LEN - 1);
        finish_sweep("bins3");
        set_exp(1, 200, 8, 800, 0, 0);
        handshake("bins3", 5);

        // Early s_last at beat 100: bin closes after 101 beats and flags an error
        fill(0);
        pw[20]   = 100;
        pw[50]   = 777;
        pw[1000] = 9999;
        begin_sweep(1, 8'h20);
        send_bin(3, 101, 100);
        finish_sweep("early_last");
        set_exp(1, 50, 3, 777, 100, 1);
        handshake("early_last", 0);

        // Next sweep starts with the error cleared
        begin_sweep(1, 8'h20);
        send_bin(4, CODE_LEN, CODE_LEN - 1);
        finish_sweep("err_clear");
        set_exp(1, 1000, 4, 9999, 777, 0);
        handshake("err_clear", 0);

        // num_bins=0 runs one bin; missing s_last closes at CODE_LEN beats with error
        fill(0);
        pw[42] = 64;
        begin_sweep(0, 8'h20);
        send_bin(6, CODE_LEN, -1);
        finish_sweep("no_last");
        set_exp(1, 42, 6, 64, 0, 1);
        handshake("no_last", 0);

        // Asynchronous reset in the middle of the second bin
        fill(0);
        pw[10] = 600;
        begin_sweep(2, 8'h20);
        send_bin(3, CODE_LEN, CODE_LEN - 1);
        for (int k = 0; k < 50; k++) send_beat(pw[k], k, 4, 1'b0);
        check("pre_reset.peak", bus.acq_peak, 600);
        check("pre_reset.busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        bus.s_valid = 1'b0;
        rst_n       = 1'b1;
        fill(0);
        pw[77]  = 321;
        pw[900] = 20;
        begin_sweep(1, 8'h20);
        send_bin(12, CODE_LEN, CODE_LEN - 1);
        finish_sweep("post_reset");
        set_exp(1, 77, 12, 321, 20, 0);
        handshake("post_reset", 0);

        // Randomized sweeps checked against the model
        for (int r = 0; r < 4; r++) begin
            int nb;
            int thr;
            int base;
            nb   = int'($urandom_range(1, 3));
            thr  = int'($urandom_range(0, 255));
            base = int'($urandom_range(0, 200));
            begin_sweep(nb, thr);
            for (int b = 0; b < nb; b++) begin
                int unsigned mx;
                mx = $urandom_range(50, 5000);
                for (int i = 0; i < CODE_LEN; i++) pw[i] = $urandom_range(0, mx);
                send_bin(base + b, CODE_LEN, CODE_LEN - 1);
            end
            finish_sweep($sformatf("rnd%0d", r));
            exp_from_model();
            handshake($sformatf("rnd%0d", r), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
